// File: rtl/armleocpu_storebuffer.sv
// Posted-write store buffer: in-order FIFO of word stores drained over a valid/ready bus,
// with a sticky write-error flag. Optional macro ARMLEOCPU_STOREBUF_HAZARD_EN selects exact
// load-address hazard detection instead of the conservative "not empty" stall.
module armleocpu_storebuffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_store_valid,
    output logic          o_store_ready,
    input  logic [AW-1:0] i_store_addr,
    input  logic [31:0]   i_store_data,
    input  logic [3:0]    i_store_mask,

    output logic          o_m_valid,
    input  logic          i_m_ready,
    output logic [AW-1:0] o_m_addr,
    output logic [31:0]   o_m_data,
    output logic [3:0]    o_m_strb,
    input  logic [1:0]    i_m_resp,

    output logic          o_empty,
    output logic [CW-1:0] o_count,

    input  logic [AW-1:0] i_load_addr,
    output logic          o_load_hazard,

    output logic          o_store_error,
    output logic [AW-1:0] o_store_error_addr,
    input  logic          i_store_error_clear
);

    localparam int unsigned PW = CW - 1;

    logic [AW-3:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [3:0]    r_strb [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PW:0]   r_wptr;
    logic [PW:0]   r_rptr;
    logic          r_error;
    logic [AW-1:0] r_error_addr;

    logic [PW-1:0] w_widx;
    logic [PW-1:0] w_ridx;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_new_error;
    logic          w_hazard;
    logic          w_unused;

    assign w_widx  = r_wptr[PW-1:0];
    assign w_ridx  = r_rptr[PW-1:0];
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == CW'(DEPTH));

    assign w_push = i_store_valid && !w_full && (i_store_mask != 4'b0000);
    assign w_pop  = !w_empty && i_m_ready;
    // A fresh error wins over a same-cycle clear and recaptures the address.
    assign w_new_error = w_pop && (i_m_resp != 2'b00) && (!r_error || i_store_error_clear);

    assign w_unused = ^{i_store_addr[1:0], i_load_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Entry storage needs no reset: contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_widx] <= i_store_addr[AW-1:2];
            r_data[w_widx] <= i_store_data;
            r_strb[w_widx] <= i_store_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error      <= 1'b0;
            r_error_addr <= '0;
        end else if (w_new_error) begin
            r_error      <= 1'b1;
            r_error_addr <= {r_addr[w_ridx], 2'b00};
        end else if (i_store_error_clear) begin
            r_error      <= 1'b0;
        end
    end

`ifdef ARMLEOCPU_STOREBUF_HAZARD_EN
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - w_ridx;
            if ((CW'(off) < w_count) && (r_addr[i] == i_load_addr[AW-1:2])) begin
                w_hazard = 1'b1;
            end
        end
    end
`else
    logic w_unused_load;
    assign w_unused_load = ^i_load_addr;
    assign w_hazard      = !w_empty;
`endif

    always_comb begin
        o_store_ready      = !w_full;
        o_m_valid          = !w_empty;
        o_m_addr           = '0;
        o_m_data           = '0;
        o_m_strb           = '0;
        if (!w_empty) begin
            o_m_addr = {r_addr[w_ridx], 2'b00};
            o_m_data = r_data[w_ridx];
            o_m_strb = r_strb[w_ridx];
        end
        o_empty            = w_empty;
        o_count            = w_count;
        o_load_hazard      = w_hazard;
        o_store_error      = r_error;
        o_store_error_addr = r_error_addr;
    end

endmodule
